// File: rtl/digital_pll_pkg.sv
// Shared constants for the digital PLL lock monitor: state encoding and default sizing.
// No logic; no latency or backpressure.
// Imported by digital_pll_lock_monitor.
package digital_pll_pkg;

    localparam int CNT_W_DEF      = 7;
    localparam int TOL_DEF        = 1;
    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 2;
    localparam int DIV_W          = 5;
    localparam int RUN_W          = 4;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_FIRST = 2'd1;
    localparam logic [1:0] ST_ACQUIRE    = 2'd2;
    localparam logic [1:0] ST_LOCKED     = 2'd3;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous reference oscillator into the PLL clock domain and flags its rising edge.
// Latency: osc rise -> osc_edge high after 2-3 clocks; osc_edge is a one-cycle pulse.
// No backpressure; free-running whenever out of reset.
module osc_edge_sync (
    input  logic clock,
    input  logic resetb,
    input  logic osc,
    output logic osc_edge
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign osc_edge = s2 & ~s3;

endmodule

// File: rtl/digital_pll_lock_monitor.sv
// PLL lock detector: counts clocks per osc period, flags lock after qualified good periods; optional osc timeout via DIGITAL_PLL_LOCK_TIMEOUT_EN.
// Latency: period/period_valid/locked update on the clock ending the synchronized edge cycle (osc rise + 2-3 clocks).
// No backpressure: period_valid is a single-cycle pulse that must be sampled when it fires.
module digital_pll_lock_monitor
    import digital_pll_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int TOL        = TOL_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             osc,
    input  logic [DIV_W-1:0] div,
    output logic             locked,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             osc_lost
);

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W:0]   TOL_W      = (CNT_W + 1)'(TOL);
    localparam logic [RUN_W-1:0] LOCK_RUN   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] UNLOCK_RUN = RUN_W'(UNLOCK_CNT);

    logic                    osc_edge;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        meas;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          diff_mag;
    logic                    good;
    logic                    timeout;
    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [RUN_W-1:0]        run;
    logic [RUN_W-1:0]        run_nxt;
    logic [RUN_W-1:0]        run_inc;
    logic                    upd;

    osc_edge_sync u_sync (
        .clock    (clock),
        .resetb   (resetb),
        .osc      (osc),
        .osc_edge (osc_edge)
    );

    // cnt is the number of clocks since the last edge minus one, so the
    // measurement is cnt+1, held at the saturation value once cnt is pinned.
    assign meas    = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    assign run_inc = run + 1'b1;

    always_comb begin
        diff     = $signed({1'b0, meas}) - $signed({{(CNT_W + 1 - DIV_W){1'b0}}, div});
        diff_mag = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        good     = (div != '0) && (diff_mag <= TOL_W);
    end

`ifdef DIGITAL_PLL_LOCK_TIMEOUT_EN
    assign timeout = (state != ST_IDLE) && (cnt == CNT_MAX) && !osc_edge;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        upd       = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_WAIT_FIRST;
            end
            ST_WAIT_FIRST: begin
                // First edge only opens the measurement window.
                if (osc_edge) begin
                    state_nxt = ST_ACQUIRE;
                    run_nxt   = '0;
                end
            end
            ST_ACQUIRE: begin
                if (osc_edge) begin
                    upd = 1'b1;
                    if (!good) begin
                        run_nxt = '0;
                    end else if (run_inc == LOCK_RUN) begin
                        state_nxt = ST_LOCKED;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (osc_edge) begin
                    upd = 1'b1;
                    if (good) begin
                        run_nxt = '0;
                    end else if (run_inc == UNLOCK_RUN) begin
                        state_nxt = ST_ACQUIRE;
                        run_nxt   = '0;
                    end else begin
                        run_nxt = run_inc;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                run_nxt   = '0;
            end
        endcase
        if (timeout) begin
            state_nxt = ST_WAIT_FIRST;
            run_nxt   = '0;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state        <= ST_IDLE;
            run          <= '0;
            cnt          <= '0;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            period       <= '0;
        end else if (!enable) begin
            // period deliberately holds so status reads survive a disable.
            state        <= ST_IDLE;
            run          <= '0;
            cnt          <= '0;
            locked       <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            run          <= run_nxt;
            locked       <= (state_nxt == ST_LOCKED);
            period_valid <= upd;
            if (upd) begin
                period <= meas;
            end
            if (osc_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DIGITAL_PLL_LOCK_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            osc_lost <= 1'b0;
        end else if (!enable || osc_edge) begin
            osc_lost <= 1'b0;
        end else if (timeout) begin
            osc_lost <= 1'b1;
        end
    end
`else
    assign osc_lost = 1'b0;
`endif

endmodule

// File: tb/tb_digital_pll_lock_monitor.sv
// Scoreboard bench for digital_pll_lock_monitor: osc ticks push expected (period, locked) pairs,
// a negedge monitor pops one per period_valid pulse; direct checks cover reset, disable and osc loss.
module tb_digital_pll_lock_monitor;

    logic       clock  = 1'b0;
    logic       resetb = 1'b0;
    logic       enable = 1'b0;
    logic       osc    = 1'b0;
    logic [4:0] div    = 5'd8;
    logic       locked;
    logic [6:0] period;
    logic       period_valid;
    logic       osc_lost;

    typedef struct packed {
        logic [6:0] period;
        logic       locked;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    digital_pll_lock_monitor dut (
        .clock        (clock),
        .resetb       (resetb),
        .enable       (enable),
        .osc          (osc),
        .div          (div),
        .locked       (locked),
        .period       (period),
        .period_valid (period_valid),
        .osc_lost     (osc_lost)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One osc cycle: low for len-2 clocks, high for 2; consecutive rises are len clocks apart.
    // The new div is applied after the previous rise has been measured.
    task automatic tick(input int len, input int d, input bit push, input int ep, input bit el);
        if (push) sb_q.push_back(exp_t'{period: 7'(ep), locked: el});
        for (int i = 0; i < len - 2; i++) begin
            @(negedge clock);
            osc = 1'b0;
            if (i == 2) div = 5'(d);
        end
        repeat (2) begin
            @(negedge clock);
            osc = 1'b1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    always @(negedge clock) begin
        if (resetb && period_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: period %0d with no pending expectation", period);
            end else begin
                mon_e = sb_q.pop_front();
                check("period", int'(period), int'(mon_e.period));
                check("locked_at_pulse", int'(locked), int'(mon_e.locked));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_locked", int'(locked), 0);
        check("reset_period", int'(period), 0);
        check("reset_period_valid", int'(period_valid), 0);
        check("reset_osc_lost", int'(osc_lost), 0);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        enable = 1'b1;

        // Lock at exact ratio, single bad tolerated, two bad drop lock.
        tick(8, 8, 0, 0, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 1);
        tick(12, 8, 1, 12, 1);
        tick(8, 8, 1, 8, 1);
        tick(12, 8, 1, 12, 1);
        tick(12, 8, 1, 12, 0);
        // Out of tolerance never locks; edge of tolerance does.
        tick(10, 8, 1, 10, 0);
        tick(10, 8, 1, 10, 0);
        tick(10, 8, 1, 10, 0);
        tick(9, 8, 1, 9, 0);
        tick(9, 8, 1, 9, 0);
        tick(9, 8, 1, 9, 0);
        tick(9, 8, 1, 9, 1);
        tick(7, 8, 1, 7, 1);
        drain();

        // Reference disappears while locked.
        @(negedge clock);
        osc = 1'b0;
        repeat (150) @(negedge clock);
`ifdef DIGITAL_PLL_LOCK_TIMEOUT_EN
        check("lost_osc_lost", int'(osc_lost), 1);
        check("lost_locked", int'(locked), 0);
        tick(8, 8, 0, 0, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 1);
        check("relock_osc_lost", int'(osc_lost), 0);
`else
        check("lost_osc_lost", int'(osc_lost), 0);
        check("lost_locked", int'(locked), 1);
        tick(8, 8, 1, 127, 1);
        tick(8, 8, 1, 8, 1);
        tick(8, 8, 1, 8, 1);
        tick(8, 8, 1, 8, 1);
`endif

        // div == 0 is always bad; then relock at div 8.
        tick(8, 0, 1, 8, 1);
        tick(8, 0, 1, 8, 0);
        tick(8, 0, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 0);
        tick(8, 8, 1, 8, 1);
        drain();

        // Disable while locked.
        repeat (5) @(negedge clock);
        check("pre_disable_locked", int'(locked), 1);
        enable = 1'b0;
        @(negedge clock);
        check("disable_locked", int'(locked), 0);
        check("disable_period_valid", int'(period_valid), 0);
        check("disable_period_hold", int'(period), 8);
        check("disable_osc_lost", int'(osc_lost), 0);

        // Re-enable, take one measurement, then async reset mid-window.
        @(negedge clock);
        enable = 1'b1;
        tick(8, 8, 0, 0, 0);
        tick(10, 8, 1, 10, 0);
        drain();
        repeat (3) @(negedge clock);
        #2;
        resetb = 1'b0;
        #1;
        check("areset_locked", int'(locked), 0);
        check("areset_period", int'(period), 0);
        check("areset_period_valid", int'(period_valid), 0);
        check("areset_osc_lost", int'(osc_lost), 0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (4) @(negedge clock);
        check("final_queue_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digital_pll_lock_monitor.md
# digital_pll_lock_monitor

Lock detector and frequency monitor for the digital PLL. The PLL controller drives the ring oscillator toward `osc × div`. This block runs on the PLL output clock and measures how many output clocks fit in each reference `osc` period. It reports the measured ratio and asserts `locked` once the ratio has stayed inside tolerance for a qualified number of reference periods. It sits beside the PLL in the clocking block; housekeeping/SPI reads its outputs for status and clock switch-over gating.

## Interface
Parameters:
- `CNT_W`, 7, width of period counter/`period` output; counter saturates at 2^CNT_W−1.
- `TOL`, 1, allowed |period − div| in clock cycles for a "good" measurement.
- `LOCK_CNT`, 4, consecutive good measurements needed to assert `locked` (1..15).
- `UNLOCK_CNT`, 2, consecutive bad measurements needed to drop `locked` (1..15).

Ports:
- `clock` input 1: PLL output clock (clockp[0]); all flops on rising edge.
- `resetb` input 1: asynchronous, active-low reset.
- `enable` input 1: monitor enable; low = synchronous clear to reset state.
- `osc` input 1: reference oscillator, asynchronous to `clock`.
- `div` input 5: expected feedback ratio (clocks per osc period).
- `locked` output 1: lock indication; reset 0.
- `period` output CNT_W: last measured clocks per osc period; reset 0.
- `period_valid` output 1: one-cycle pulse when `period` updates; reset 0.
- `osc_lost` output 1: reference missing (timeout); reset 0. Tied 0 when timeout is compiled out.

## Operation
- `osc` is synchronized by 2 flops (s1, s2) plus history flop s3. `edge = s2 & ~s3`.
- Counter `cnt` (CNT_W): resets to 0 and increments every clock. It saturates at all-ones. On an `edge` cycle it loads 0.
- Measurement on an edge cycle: `m = sat(cnt + 1)`, meaning the clocks elapsed since the previous edge.
- Good measurement: `div != 0` and `|m − div| <= TOL`, computed at CNT_W+1 bits signed. `div == 0` is always bad.
- States: IDLE, WAIT_FIRST, ACQUIRE, LOCKED. Good/bad run counter `run` is 4 bits.
  - IDLE: entered on reset or `enable`=0. When `enable`=1 → WAIT_FIRST.
  - WAIT_FIRST: the first edge only starts the window. `m` is discarded, there is no `period_valid`, and the state moves to ACQUIRE with run=0.
  - ACQUIRE: on each edge, `period`←m and `period_valid`=1. Good: run+1; if run+1 == LOCK_CNT → LOCKED with run=0. Bad: run=0.
  - LOCKED: on each edge, `period`←m and `period_valid`=1. Good: run=0. Bad: run+1; if run+1 == UNLOCK_CNT → ACQUIRE with run=0.
- `locked` = (state == LOCKED), registered.
- `enable` low in any state: next clock sets state IDLE and clears cnt, run, `locked`, `period_valid`, and `osc_lost`. `period` holds its last value. The synchronizer keeps running.
- `div` change mid-operation: no special handling. The next measurement compares against the new `div`.

## Timing
- `osc` rise → `edge` after 2–3 clocks (synchronizer latency).
- `period`, `period_valid`, state, and `locked` all update on the clock edge that ends the `edge` cycle. There is no extra pipeline stage.
- Minimum lock time after enable: 1 discarded edge + LOCK_CNT good edges.
- Saturation: when m reaches 2^CNT_W−1 it is reported as that value, which is bad for any div ≤ 31 with TOL < 96.
- Async reset mid-measurement: all outputs go to their reset values immediately.

## Configuration
- `DIGITAL_PLL_LOCK_TIMEOUT_EN` defined:
  - If `cnt` reaches saturation (no osc edge for 2^CNT_W−1 clocks) in WAIT_FIRST, ACQUIRE, or LOCKED, then next clock: `osc_lost`=1, `locked`=0, state→WAIT_FIRST, run=0.
  - `osc_lost` clears on the next `edge` or on `enable`=0.
- Not defined: no timeout. `osc_lost` is constant 0, and state changes only on edges.

## Structure
- Package `digital_pll_pkg`: state encoding (IDLE=0, WAIT_FIRST=1, ACQUIRE=2, LOCKED=3), default parameter constants, and the `run` width constant.
- One sub-module, `osc_edge_sync`: the 3-flop synchronizer and rising-edge detector with async active-low reset. Outputs `edge`.

## Test plan
- div=8, osc period exactly 8 clocks, enable=1 → first edge discarded; four `period_valid` pulses with period=8; `locked`=1 on the 4th.
- div=8, osc period 10 clocks → period=10 each edge; `locked` never asserts. Period 9 → locks (TOL=1).
- Locked at div=8, then 2 osc periods of 12 clocks → `locked` drops at the 2nd bad edge. A single bad period followed by a good one → stays locked.
- Timeout macro on, locked, osc held low → after 127 clocks `osc_lost`=1 and `locked`=0. Restarting osc → `osc_lost` clears at first edge and relock completes after 1+4 edges. Macro off → `osc_lost` stays 0 and `locked` stays 1.
- enable dropped while locked → next clock `locked`=0, `period_valid`=0, `period` holds 8. Async resetb pulse → all outputs 0.
- div=0 with any osc → `period_valid` pulses, `locked` stays 0.
